// File: rtl/jt89_wr.sv
// Write sequencer for an SN76489-style PSG: turns tone/volume/noise commands into
// latch/data bytes with a registered active-low write strobe and optional tone-hi suppression.
module jt89_wr #(
  parameter int unsigned WR_LOW  = 2,
  parameter int unsigned WR_GAP  = 2,
  parameter bit          SKIP_HI = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       clr_shadow,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [1:0] cmd_ch,
  input  logic [9:0] cmd_data,
  output logic [7:0] dout,
  output logic       wr_n,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP} state_t;

  localparam int unsigned CNT_MAX = (WR_LOW > WR_GAP) ? WR_LOW : WR_GAP;
  localparam int          CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LOW_LOAD = CW'(WR_LOW - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(WR_GAP - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;     // tone data byte still to be sent
  logic          sec_q, sec_d;       // byte in flight is the tone data byte
  logic [5:0]    hi_q, hi_d;
  logic [1:0]    ch_q, ch_d;
  logic [7:0]    dout_q, dout_d;
  logic          wr_n_q, wr_n_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          cmd_tone, cmd_emit;
  logic [2:0]    hit;
  logic          upd_shadow;
  logic [7:0]    first_byte;

  assign accept   = cmd_valid & ready_q & clk_en;
  assign cmd_tone = (cmd_type == 2'd0) && (cmd_ch != 2'd3);
  assign cmd_emit = cmd_tone || (cmd_type == 2'd1) || (cmd_type == 2'd2);

  // The shadow is committed as the data byte moves into its strobe.
  assign upd_shadow = (state_q == S_SETUP) && clk_en && sec_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_shadow
      logic [5:0] sh_q;
      logic       vld_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sh_q  <= '0;
          vld_q <= 1'b0;
        end else if (clr_shadow) begin
          vld_q <= 1'b0;
        end else if (upd_shadow && (ch_q == 2'(gi))) begin
          sh_q  <= hi_q;
          vld_q <= 1'b1;
        end
      end

      assign hit[gi] = vld_q && (sh_q == cmd_data[9:4]) && (cmd_ch == 2'(gi));
    end
  endgenerate

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      sec_q   <= 1'b0;
      hi_q    <= '0;
      ch_q    <= '0;
      dout_q  <= '0;
      wr_n_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sec_q   <= sec_d;
      hi_q    <= hi_d;
      ch_q    <= ch_d;
      dout_q  <= dout_d;
      wr_n_q  <= wr_n_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    sec_d   = sec_q;
    hi_d    = hi_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hi_d   = cmd_data[9:4];
          ch_d   = cmd_ch;
          sec_d  = 1'b0;
          pend_d = cmd_tone && !(SKIP_HI && (|hit));
          if (cmd_emit) state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (clk_en) begin
          state_d = S_STROBE;
          cnt_d   = LOW_LOAD;
        end
      end
      S_STROBE: begin
        if (clk_en) begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (clk_en) begin
          if (cnt_q == '0) begin
            if (pend_q) begin
              state_d = S_SETUP;
              pend_d  = 1'b0;
              sec_d   = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: everything is registered from the next state
  always_comb begin
    case (cmd_type)
      2'd0:    first_byte = {1'b1, cmd_ch, 1'b0, cmd_data[3:0]};
      2'd1:    first_byte = {1'b1, cmd_ch, 1'b1, cmd_data[3:0]};
      default: first_byte = {5'b11100, cmd_data[2:0]};
    endcase

    dout_d = dout_q;
    if ((state_q == S_IDLE) && (state_d == S_SETUP)) begin
      dout_d = first_byte;
    end else if ((state_q == S_GAP) && (state_d == S_SETUP)) begin
      dout_d = {2'b00, hi_q};
    end

    wr_n_d  = (state_d != S_STROBE);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign cmd_ready = ready_q;
  assign dout      = dout_q;
  assign wr_n      = wr_n_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_jt89_wr.sv
// Scoreboard bench for jt89_wr: a command model pushes expected PSG bytes,
// a strobe monitor pops and compares them and checks strobe/gap widths.
module tb_jt89_wr;

  localparam int WL = 2;
  localparam int WG = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       clr_shadow = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_valid2 = 1'b0;
  logic [1:0] cmd_type = 2'd0;
  logic [1:0] cmd_ch = 2'd0;
  logic [9:0] cmd_data = 10'd0;
  logic       cmd_ready, cmd_ready2;
  logic [7:0] dout, dout2;
  logic       wr_n, wr_n2;
  logic       busy, busy2;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [5:0] m_sh[4];
  bit         m_v[4];

  int en_div = 1;
  int ph = 0;
  bit chk_width = 1'b1;

  jt89_wr #(.WR_LOW(WL), .WR_GAP(WG), .SKIP_HI(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .clr_shadow(clr_shadow),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_ch(cmd_ch), .cmd_data(cmd_data), .dout(dout), .wr_n(wr_n), .busy(busy)
  );

  jt89_wr #(.WR_LOW(WL), .WR_GAP(WG), .SKIP_HI(1'b0)) dut_noskip (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .clr_shadow(clr_shadow),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_type(cmd_type),
    .cmd_ch(cmd_ch), .cmd_data(cmd_data), .dout(dout2), .wr_n(wr_n2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // Enable pattern: 1 of every en_div edges, set shortly after each edge.
  always @(posedge clk) begin
    #2;
    ph = (ph + 1 >= en_div) ? 0 : ph + 1;
    clk_en = (ph == 0);
  end

  // Strobe monitor
  logic       prev_wr = 1'b1;
  int         low_cnt = 0;
  int         hi_cnt = 1000;
  logic [7:0] held;
  logic [7:0] e;

  always @(negedge clk) begin
    if (prev_wr === 1'b1 && wr_n === 1'b0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL strobe_unexpected: dout=%02h, no byte expected", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          fails++;
          $display("FAIL strobe_byte: dout=%02h expected=%02h", dout, e);
        end else begin
          $display("[TB] strobe byte %02h", dout);
        end
      end
      if (chk_width) begin
        tests++;
        if (hi_cnt < (WG + 1) * en_div) begin
          fails++;
          $display("FAIL strobe_gap: high cycles=%0d expected>=%0d", hi_cnt, (WG + 1) * en_div);
        end
      end
      held = dout;
      low_cnt = 1;
    end else if (wr_n === 1'b0) begin
      low_cnt++;
      tests++;
      if (dout !== held) begin
        fails++;
        $display("FAIL dout_stable: dout=%02h expected=%02h while wr_n low", dout, held);
      end
    end else if (prev_wr === 1'b0 && wr_n === 1'b1) begin
      if (chk_width) begin
        tests++;
        if (low_cnt != WL * en_div) begin
          fails++;
          $display("FAIL strobe_width: low cycles=%0d expected=%0d", low_cnt, WL * en_div);
        end
      end
      hi_cnt = 1;
    end else begin
      hi_cnt++;
    end
    prev_wr = wr_n;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic [1:0] t, input logic [1:0] ch, input logic [9:0] d);
    case (t)
      2'd0: begin
        if (ch != 2'd3) begin
          exp_q.push_back({1'b1, ch, 1'b0, d[3:0]});
          if (!(m_v[ch] && m_sh[ch] == d[9:4])) begin
            exp_q.push_back({2'b00, d[9:4]});
            m_sh[ch] = d[9:4];
            m_v[ch] = 1'b1;
          end
        end
      end
      2'd1: exp_q.push_back({1'b1, ch, 1'b1, d[3:0]});
      2'd2: exp_q.push_back({5'b11100, d[2:0]});
      default: ;
    endcase
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
  endtask

  // Issue one command; lat = negedges after the accept edge until cmd_ready is back.
  task automatic send(input logic [1:0] t, input logic [1:0] ch, input logic [9:0] d,
                      output int lat);
    int n;
    @(negedge clk);
    cmd_type = t; cmd_ch = ch; cmd_data = d; cmd_valid = 1'b1;
    n = 0;
    while (!(cmd_ready === 1'b1 && clk_en === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++; fails++;
      $display("FAIL accept_timeout: cmd_ready=%b expected=1", cmd_ready);
      cmd_valid = 1'b0;
      lat = -1;
      return;
    end
    push_cmd(t, ch, d);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data = 10'($urandom);
    lat = 0;
    while (cmd_ready !== 1'b1 && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    $display("[TB] cmd type=%0d ch=%0d data=%03h ready_after=%0d", t, ch, d, lat);
  endtask

  task automatic check_drained(input string name);
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drained: pending bytes=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests += 4;
    if (wr_n !== 1'b1) begin fails++; $display("FAIL reset_wr_n: got=%b expected=1", wr_n); end
    if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got=%02h expected=00", dout); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got=%b expected=0", busy); end
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got=%b expected=0", cmd_ready); end
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got=%b expected=1", cmd_ready); end
  endtask

  task automatic test_tone();
    int lat;
    send(2'd0, 2'd1, 10'h2A5, lat);
    tests++;
    if (lat != 10) begin fails++; $display("FAIL tone_latency: got=%0d expected=10", lat); end
    check_drained("tone");
  endtask

  task automatic test_skip();
    int lat;
    send(2'd0, 2'd1, 10'h2A3, lat);
    tests++;
    if (lat != 5) begin fails++; $display("FAIL skip_latency: got=%0d expected=5", lat); end
    send(2'd0, 2'd1, 10'h1A3, lat);
    tests++;
    if (lat != 10) begin fails++; $display("FAIL skip_change_latency: got=%0d expected=10", lat); end
    check_drained("skip");
  endtask

  task automatic test_vol_noise();
    int lat;
    send(2'd1, 2'd3, 10'h007, lat);
    tests++;
    if (lat != 5) begin fails++; $display("FAIL vol_latency: got=%0d expected=5", lat); end
    send(2'd2, 2'd0, 10'h3FD, lat);
    tests++;
    if (lat != 5) begin fails++; $display("FAIL noise_latency: got=%0d expected=5", lat); end
    send(2'd3, 2'd2, 10'h3FF, lat);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reserved_busy: got=%b expected=0", busy); end
    send(2'd0, 2'd3, 10'h123, lat);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reserved_tone_busy: got=%b expected=0", busy); end
    check_drained("vol_noise");
  endtask

  task automatic test_clr_shadow();
    int lat;
    @(negedge clk);
    clr_shadow = 1'b1;
    clear_model();
    @(negedge clk);
    clr_shadow = 1'b0;
    send(2'd0, 2'd1, 10'h2A3, lat);
    tests++;
    if (lat != 10) begin fails++; $display("FAIL clr_latency: got=%0d expected=10", lat); end
    check_drained("clr_shadow");
  endtask

  task automatic test_noskip();
    logic [7:0] got[4];
    logic       p2;
    int         nb;
    int         n;
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      cmd_type = 2'd0; cmd_ch = 2'd1; cmd_data = 10'h2A3; cmd_valid2 = 1'b1;
      n = 0;
      while (cmd_ready2 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      p2 = wr_n2;
      @(negedge clk);
      cmd_valid2 = 1'b0;
      nb = 0;
      for (int c = 0; c < 30; c++) begin
        if (p2 === 1'b1 && wr_n2 === 1'b0 && nb < 4) begin
          got[nb] = dout2;
          nb++;
        end
        p2 = wr_n2;
        @(negedge clk);
      end
      $display("[TB] noskip tone rep=%0d strobes=%0d", rep, nb);
      tests++;
      if (nb != 2) begin
        fails++;
        $display("FAIL noskip_count: strobes=%0d expected=2", nb);
      end else begin
        tests += 2;
        if (got[0] !== 8'hA3) begin fails++; $display("FAIL noskip_latch: got=%02h expected=a3", got[0]); end
        if (got[1] !== 8'h2A) begin fails++; $display("FAIL noskip_data: got=%02h expected=2a", got[1]); end
      end
    end
  endtask

  task automatic test_enable_gating();
    int lat;
    int n;
    en_div = 3;
    repeat (6) @(negedge clk);
    n = 0;
    while (!(clk_en === 1'b0 && cmd_ready === 1'b1) && n < 20) begin @(negedge clk); n++; end
    cmd_type = 2'd1; cmd_ch = 2'd0; cmd_data = 10'h00A; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL gated_no_accept: busy=%b expected=0", busy); end
    send(2'd1, 2'd0, 10'h00A, lat);
    tests++;
    if (lat != 5 * 3) begin fails++; $display("FAIL gated_vol_latency: got=%0d expected=15", lat); end
    send(2'd0, 2'd2, 10'h155, lat);
    tests++;
    if (lat != 10 * 3) begin fails++; $display("FAIL gated_tone_latency: got=%0d expected=30", lat); end
    check_drained("gating");
    en_div = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_strobe();
    int lat;
    int n;
    @(negedge clk);
    cmd_type = 2'd0; cmd_ch = 2'd1; cmd_data = 10'h2A3; cmd_valid = 1'b1;
    n = 0;
    while (!(cmd_ready === 1'b1 && clk_en === 1'b1) && n < 100) begin @(negedge clk); n++; end
    push_cmd(2'd0, 2'd1, 10'h2A3);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (wr_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (n >= 20) begin fails++; $display("FAIL midrst_no_strobe: wr_n=%b expected=0", wr_n); end
    @(negedge clk);
    rst_n = 1'b0;
    chk_width = 1'b0;
    exp_q.delete();
    clear_model();
    @(negedge clk);
    tests += 3;
    if (wr_n !== 1'b1) begin fails++; $display("FAIL midrst_wr_n: got=%b expected=1", wr_n); end
    if (dout !== 8'h00) begin fails++; $display("FAIL midrst_dout: got=%02h expected=00", dout); end
    if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got=%b expected=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    chk_width = 1'b1;
    send(2'd0, 2'd1, 10'h2A3, lat);
    tests++;
    if (lat != 10) begin fails++; $display("FAIL midrst_tone_latency: got=%0d expected=10", lat); end
    check_drained("midrst");
  endtask

  initial begin
    test_reset();
    test_tone();
    test_skip();
    test_vol_noise();
    test_clr_shadow();
    test_noskip();
    test_enable_gating();
    test_reset_mid_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
